// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants, block-count helper and result type for the adder/subtractor family
//
// Purpose : common definitions imported by the carry-bypass arithmetic blocks.
// Contents: ARITH_WIDTH / ARITH_BLK defaults, num_blocks() block-count helper,
//           arith_res_t {diff, bout, ovf} result record.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;
  localparam int ARITH_BLK   = 2;

  // Number of bypass blocks in a WIDTH-bit datapath built from BLK-bit slices.
  function automatic int num_blocks(input int width, input int blk);
    return width / blk;
  endfunction

  typedef struct packed {
    logic [ARITH_WIDTH-1:0] diff;
    logic                   bout;
    logic                   ovf;
  } arith_res_t;

endpackage

// File: rtl/carry_bypass_blk.sv
// rtl/carry_bypass_blk.sv - BLK-bit ripple slice with block propagate and carry bypass mux
//
// Purpose : one carry-bypass block. Ripples the carry through BLK bits and, when
//           every bit propagates, forwards ci straight to co (the skip path).
// Ports   : x, y [BLK-1:0]  addend bits (for subtraction y is the inverted subtrahend)
//           ci              carry in
//           s  [BLK-1:0]    sum bits
//           co              carry out (bypass-selected)
//           p               block propagate, 1 when x[i]^y[i] for every bit
module carry_bypass_blk
  import arith_pkg::*;
#(
  parameter int BLK = ARITH_BLK
) (
  input  logic [BLK-1:0] x,
  input  logic [BLK-1:0] y,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           p
);

  logic [BLK:0] rc;

  always_comb begin
    rc    = '0;
    s     = '0;
    rc[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      s[i]    = x[i] ^ y[i] ^ rc[i];
      rc[i+1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & rc[i]);
    end
    p  = &(x ^ y);
    // When the whole block propagates the ripple result equals ci, so the mux
    // only shortens the path; the value is identical either way.
    co = p ? ci : rc[BLK];
  end

endmodule

// File: rtl/carry_bypass_sub8_pipe.sv
// rtl/carry_bypass_sub8_pipe.sv - two-stage pipelined carry-bypass subtractor with valid/ready handshake
//
// Purpose : diff = a - b - bin, computed as a + ~b + !bin through carry-bypass
//           blocks. Low half resolves in stage 1, high half in stage 2.
// Ports   : clk, rst           clock, synchronous active-high reset
//           in_valid/in_ready  operand handshake (a, b, bin)
//           out_valid/out_ready result handshake (diff, bout, ovf, bypass)
//           diff   (a - b - bin) mod 2^WIDTH
//           bout   borrow out, 1 when a < b + bin
//           ovf    signed overflow
//           bypass per-block flag, 1 where the skip path was taken
module carry_bypass_sub8_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH,
  parameter int BLK   = ARITH_BLK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     diff,
  output logic                 bout,
  output logic                 ovf,
  output logic [WIDTH/BLK-1:0] bypass
);

  localparam int NB = num_blocks(WIDTH, BLK);
  localparam int HB = NB / 2;
  localparam int HW = WIDTH / 2;

  // ---------------- stage 1: low half ----------------
  logic [WIDTH-1:0] b_inv;
  logic [HB:0]      c_lo;
  logic [HW-1:0]    sum_lo;
  logic [HB-1:0]    p_lo;

  assign b_inv   = ~b;
  assign c_lo[0] = ~bin;   // subtract borrow-in becomes an inverted carry-in

  for (genvar k = 0; k < HB; k++) begin : g_lo
    carry_bypass_blk #(.BLK(BLK)) u_blk (
      .x  (a[k*BLK +: BLK]),
      .y  (b_inv[k*BLK +: BLK]),
      .ci (c_lo[k]),
      .s  (sum_lo[k*BLK +: BLK]),
      .co (c_lo[k+1]),
      .p  (p_lo[k])
    );
  end

  // ---------------- pipeline registers ----------------
  logic             s1_valid_q, s1_valid_d;
  logic [HW-1:0]    diff_lo_q, diff_lo_d;
  logic             c_mid_q, c_mid_d;
  logic [HB-1:0]    byp_lo_q, byp_lo_d;
  logic [HW-1:0]    a_hi_q, a_hi_d;
  logic [HW-1:0]    b_inv_hi_q, b_inv_hi_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic [NB-1:0]    bypass_q, bypass_d;

  // ---------------- stage 2: high half ----------------
  logic [HB:0]      c_hi;
  logic [HW-1:0]    sum_hi;
  logic [HB-1:0]    p_hi;

  assign c_hi[0] = c_mid_q;

  for (genvar k = 0; k < HB; k++) begin : g_hi
    carry_bypass_blk #(.BLK(BLK)) u_blk (
      .x  (a_hi_q[k*BLK +: BLK]),
      .y  (b_inv_hi_q[k*BLK +: BLK]),
      .ci (c_hi[k]),
      .s  (sum_hi[k*BLK +: BLK]),
      .co (c_hi[k+1]),
      .p  (p_hi[k])
    );
  end

  // ---------------- handshake ----------------
  logic s1_ready, s2_ready;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    diff_lo_d  = diff_lo_q;
    c_mid_d    = c_mid_q;
    byp_lo_d   = byp_lo_q;
    a_hi_d     = a_hi_q;
    b_inv_hi_d = b_inv_hi_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    bypass_d   = bypass_q;

    // Stage 1 refills whenever it is empty or its contents move on this edge.
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        diff_lo_d  = sum_lo;
        c_mid_d    = c_lo[HB];
        byp_lo_d   = p_lo;
        a_hi_d     = a[WIDTH-1:HW];
        b_inv_hi_d = b_inv[WIDTH-1:HW];
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d   = {sum_hi, diff_lo_q};
        bout_d   = ~c_hi[HB];
        // Sign of b is recovered from the stored inverted subtrahend.
        ovf_d    = (a_hi_q[HW-1] != ~b_inv_hi_q[HW-1]) && (sum_hi[HW-1] != a_hi_q[HW-1]);
        bypass_d = {p_hi, byp_lo_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      diff_lo_q  <= '0;
      c_mid_q    <= 1'b0;
      byp_lo_q   <= '0;
      a_hi_q     <= '0;
      b_inv_hi_q <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bypass_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      diff_lo_q  <= diff_lo_d;
      c_mid_q    <= c_mid_d;
      byp_lo_q   <= byp_lo_d;
      a_hi_q     <= a_hi_d;
      b_inv_hi_q <= b_inv_hi_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
      bypass_q   <= bypass_d;
    end
  end

  assign in_ready  = s1_ready;
  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign bypass    = bypass_q;

endmodule
